// File: rtl/mem_access_unit.sv
// Data-memory initiator: turns CPU byte/half/word loads and stores into word or byte beats.
// Optional build macro MEM_MISALIGN_SPLIT_EN splits misaligned words into four byte beats.
//
// state  | meaning
// IDLE   | ready for a request; mem_* idle
// ACCESS | one memory beat per cycle, mem_* driven
// RESP   | one-cycle completion pulse on rsp_valid
module mem_access_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int BYTE_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_we,
  output logic                     mem_byteop,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                   state;
  logic                     we_q;
  logic                     uns_q;
  logic                     byteop_q;
  logic                     mem_we_q;
  logic [1:0]               size_q;
  logic [1:0]               beat;
  logic [1:0]               beat_last;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    acc_q;

  logic                     req_err;
  logic                     req_split;
  logic                     req_byteop;
  logic [1:0]               req_last;
  logic [DATA_WIDTH-1:0]    acc_next;
  logic [DATA_WIDTH-1:0]    ext_data;
  logic [DATA_WIDTH-1:0]    load_result;

  // Byte idx counted from the least significant lane; beat k of N sends lane N-1-k.
  function automatic logic [DATA_WIDTH-1:0] lane(input logic [DATA_WIDTH-1:0] w,
                                                 input logic [1:0] idx);
    logic [BYTE_WIDTH-1:0] b;
    b = w[BYTE_WIDTH*int'(idx) +: BYTE_WIDTH];
    return DATA_WIDTH'(b);
  endfunction

  always_comb begin
    req_err   = 1'b0;
    req_split = 1'b0;
    req_last  = 2'd0;
    case (req_size)
      2'b00: ;
      2'b01: begin
        req_last = 2'd1;
        req_err  = req_addr[0];
      end
      2'b10: begin
        if (req_addr[1:0] != 2'b00) begin
`ifdef MEM_MISALIGN_SPLIT_EN
          req_split = 1'b1;
          req_last  = 2'd3;
`else
          req_err   = 1'b1;
`endif
        end
      end
      default: req_err = 1'b1;
    endcase
    req_byteop = !((req_size == 2'b10) && !req_split);
  end

  // Byte beats shift in big-endian order, so beat 0 ends up most significant.
  always_comb begin
    acc_next = byteop_q ? {acc_q[DATA_WIDTH-BYTE_WIDTH-1:0], mem_rdata[BYTE_WIDTH-1:0]}
                        : mem_rdata;
    case (size_q)
      2'b00: ext_data = uns_q ? DATA_WIDTH'(acc_next[BYTE_WIDTH-1:0])
                              : {{(DATA_WIDTH-BYTE_WIDTH){acc_next[BYTE_WIDTH-1]}},
                                 acc_next[BYTE_WIDTH-1:0]};
      2'b01: ext_data = uns_q ? DATA_WIDTH'(acc_next[2*BYTE_WIDTH-1:0])
                              : {{(DATA_WIDTH-2*BYTE_WIDTH){acc_next[2*BYTE_WIDTH-1]}},
                                 acc_next[2*BYTE_WIDTH-1:0]};
      default: ext_data = acc_next;
    endcase
    load_result = we_q ? '0 : ext_data;
  end

  // A reset landing mid-beat must not let that beat's write reach memory.
  assign mem_we = mem_we_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= 2'd0;
      beat_last  <= 2'd0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      byteop_q   <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      acc_q      <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_byteop <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            uns_q     <= req_unsigned;
            size_q    <= req_size;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            byteop_q  <= req_byteop;
            beat      <= 2'd0;
            beat_last <= req_last;
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state      <= ACCESS;
              mem_we_q   <= req_we;
              mem_byteop <= req_byteop;
              mem_addr   <= req_addr;
              mem_wdata  <= req_byteop ? lane(req_wdata, req_last) : req_wdata;
            end
          end
        end
        ACCESS: begin
          acc_q <= acc_next;
          if (beat == beat_last) begin
            state      <= RESP;
            mem_we_q   <= 1'b0;
            mem_byteop <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rsp_valid  <= 1'b1;
            rsp_err    <= 1'b0;
            rsp_rdata  <= load_result;
          end else begin
            beat      <= beat + 2'd1;
            mem_addr  <= addr_q + ADDRESS_WIDTH'(beat + 2'd1);
            mem_wdata <= byteop_q ? lane(wdata_q, beat_last - beat - 2'd1) : wdata_q;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: byte-array memory, directed cases, then random
// requests checked against a byte-level reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic        mem_byteop;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_init;

  logic [7:0]  dmem [4096];
  logic [7:0]  rmem [4096];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_we(mem_we), .mem_byteop(mem_byteop),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Big-endian word view over a 4 KiB aliased byte store.
  assign mem_rdata = mem_byteop ? {24'h0, dmem[mem_addr[11:0]]}
                                : {dmem[{mem_addr[11:2], 2'd0}], dmem[{mem_addr[11:2], 2'd1}],
                                   dmem[{mem_addr[11:2], 2'd2}], dmem[{mem_addr[11:2], 2'd3}]};

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) dmem[i] <= 8'(i * 7 + 3);
    end else if (mem_we) begin
      if (mem_byteop) begin
        dmem[mem_addr[11:0]] <= mem_wdata[7:0];
      end else begin
        dmem[{mem_addr[11:2], 2'd0}] <= mem_wdata[31:24];
        dmem[{mem_addr[11:2], 2'd1}] <= mem_wdata[23:16];
        dmem[{mem_addr[11:2], 2'd2}] <= mem_wdata[15:8];
        dmem[{mem_addr[11:2], 2'd3}] <= mem_wdata[7:0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return rmem[a[11:0]];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input int nb,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < nb; k++) v = (v << 8) | 32'(ref_byte(addr + 32'(k)));
    case (size)
      2'b00:   return uns ? (v & 32'hFF)   : 32'($signed(v[7:0]));
      2'b01:   return uns ? (v & 32'hFFFF) : 32'($signed(v[15:0]));
      default: return v;
    endcase
  endfunction

  // Caller is at a negedge with the unit idle; returns at the negedge after RESP.
  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd);
    int         n;
    int         nb;
    int         cyc;
    int         beats;
    logic       err;
    logic       wordop;
    logic       got;
    logic [7:0] sb [4];
    logic [31:0] exp_rd;
    err = 1'b0; n = 1; wordop = 1'b0;
    case (size)
      2'b00: n = 1;
      2'b01: begin n = 2; err = addr[0]; end
      2'b10: begin
        if (addr[1:0] == 2'b00) wordop = 1'b1;
`ifdef MEM_MISALIGN_SPLIT_EN
        else n = 4;
`else
        else err = 1'b1;
`endif
      end
      default: err = 1'b1;
    endcase
    nb = wordop ? 4 : n;
    for (int k = 0; k < 4; k++) sb[k] = (k < nb) ? 8'(wdata >> (8 * (nb - 1 - k))) : 8'h0;
    exp_rd = (err || we) ? 32'h0 : model_load(addr, nb, size, uns);

    check("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

    cyc = 0; beats = 0; got = 1'b0;
    while (cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      check("beat_addr", mem_addr, addr + 32'(beats));
      check("beat_byteop", 32'(mem_byteop), 32'(!wordop));
      check("beat_we", 32'(mem_we), 32'(we));
      check("beat_ready_low", 32'(req_ready), 32'd0);
      if (we && beats < 4)
        check("beat_wdata", wordop ? mem_wdata : {24'h0, mem_wdata[7:0]},
              wordop ? wdata : {24'h0, sb[beats]});
      beats++;
    end
    check("rsp_seen", 32'(got), 32'd1);
    check("rsp_latency", 32'(cyc), err ? 32'd1 : 32'(n + 1));
    check("beat_count", 32'(beats), err ? 32'd0 : 32'(n));
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_rdata", rsp_rdata, exp_rd);
    rd = rsp_rdata;
    if (we && !err)
      for (int k = 0; k < nb; k++) begin
        logic [31:0] a;
        a = addr + 32'(k);
        rmem[a[11:0]] = sb[k];
      end
    @(negedge clk);
    check("ready_after_rsp", 32'(req_ready), 32'd1);
    check("rsp_single_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_first;
    logic [31:0] exp_second;
    logic [31:0] first_rd;
    logic [31:0] second_rd;
    int          accepts;
    int          pulses;
    int          bad;

    for (int i = 0; i < 4096; i++) rmem[i] = 8'(i * 7 + 3);
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    rst = 1'b1; mem_init = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_byteop", 32'(mem_byteop), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);

    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, rd);
    check("sw_byte100", 32'(dmem[12'h100]), 32'hDE);
    check("sw_byte101", 32'(dmem[12'h101]), 32'hAD);
    check("sw_byte102", 32'(dmem[12'h102]), 32'hBE);
    check("sw_byte103", 32'(dmem[12'h103]), 32'hEF);
    run_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rd);
    check("lw_value", rd, 32'hDEADBEEF);
    run_req(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, rd);
    check("lb_value", rd, 32'hFFFFFFAD);
    run_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, rd);
    check("lbu_value", rd, 32'h000000AD);
    run_req(1'b1, 2'b01, 1'b0, 32'h202, 32'h00008001, rd);
    check("sh_byte202", 32'(dmem[12'h202]), 32'h80);
    check("sh_byte203", 32'(dmem[12'h203]), 32'h01);
    run_req(1'b0, 2'b01, 1'b0, 32'h202, 32'h0, rd);
    check("lh_value", rd, 32'hFFFF8001);
    run_req(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, rd);
    check("lhu_value", rd, 32'h00008001);
    run_req(1'b0, 2'b10, 1'b0, 32'h103, 32'h0, rd);
    run_req(1'b1, 2'b01, 1'b0, 32'h201, 32'h1234, rd);
    check("sh_misaligned_nowrite", 32'(dmem[12'h201]), 32'(rmem[12'h201]));
    run_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, rd);
    run_req(1'b1, 2'b11, 1'b0, 32'h104, 32'h55, rd);
    run_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFD, 32'h11223344, rd);
    run_req(1'b0, 2'b10, 1'b0, 32'hFFFFFFFD, 32'h0, rd);

    // Reset during the second beat of a halfword store.
    check("rst_test_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h0000ABCD;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rst_beat0_addr", mem_addr, 32'h300);
    check("rst_beat0_wdata", {24'h0, mem_wdata[7:0]}, 32'hAB);
    @(negedge clk);
    check("rst_beat1_addr", mem_addr, 32'h301);
    rst = 1'b1;
    #1 check("rst_gates_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_abort_ready", 32'(req_ready), 32'd1);
    check("rst_abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_abort_mem_addr", mem_addr, 32'h0);
    rmem[12'h300] = 8'hAB;
    check("rst_byte300", 32'(dmem[12'h300]), 32'hAB);
    check("rst_byte301", 32'(dmem[12'h301]), 32'(rmem[12'h301]));
    run_req(1'b0, 2'b01, 1'b1, 32'h300, 32'h0, rd);

    // req_valid held high across a busy halfword load.
    exp_first  = {16'h0, rmem[12'h202], rmem[12'h203]};
    exp_second = {24'h0, rmem[12'h100]};
    first_rd = 32'h0; second_rd = 32'h0; accepts = 0; pulses = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b01; req_unsigned = 1'b1;
    req_addr = 32'h202; req_wdata = 32'h0;
    @(posedge clk);
    #1 begin req_size = 2'b00; req_addr = 32'h100; end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("hold_ready", 32'(req_ready), (c == 4) ? 32'd1 : 32'd0);
      if (req_valid && req_ready) accepts++;
      if (rsp_valid) first_rd = rsp_rdata;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 5; c <= 9; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        pulses++;
        second_rd = rsp_rdata;
        check("hold_second_latency", 32'(c), 32'd6);
      end
    end
    check("hold_accepts", 32'(accepts), 32'd1);
    check("hold_first_rdata", first_rd, exp_first);
    check("hold_second_pulses", 32'(pulses), 32'd1);
    check("hold_second_rdata", second_rd, exp_second);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : (32'h400 + 32'($urandom_range(0, 255)));
      run_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, rd);
    end

    bad = 0;
    for (int i = 0; i < 4096; i++) if (dmem[i] !== rmem[i]) bad++;
    check("mem_image", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
